// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM encoding and bit-timing math.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4,
        PARITY = 3'd5
    } uart_rx_state_t;

    function automatic int calc_bit_cycles(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset level is a parameter so an
// idle-high line can be preset high and never produce a spurious edge out of reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes the line, frames LSB-first bytes and strobes valid/framing error.
// Define UART_RX_PARITY_EN to add an even-parity bit and the uart_parity_err output.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter logic [27:0] CLOCK_FREQ = 28'd50000000,
    parameter logic [23:0] BAUD_RATE  = 24'd4000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      uart_rx_d_in,
    output logic [UART_DATA_BITS-1:0] uart_received_data,
    output logic                      uart_rx_valid,
    output logic                      uart_frame_err,
    output logic                      uart_rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                      uart_parity_err
`endif
);

    localparam int BIT_CYCLES  = calc_bit_cycles(int'(CLOCK_FREQ), int'(BAUD_RATE));
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CNT_W       = $clog2(BIT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT_IDX  = 3'(UART_DATA_BITS - 1);

    generate
        if (BIT_CYCLES < 4) begin : g_bit_cycles_check
            $error("uart_rx_deserializer: CLOCK_FREQ/BAUD_RATE must be at least 4");
        end
    endgenerate

    logic rx_s;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (uart_rx_d_in),
        .q_o   (rx_s)
    );

    uart_rx_state_t            state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [2:0]                bit_idx_q;
    logic [UART_DATA_BITS-1:0] shift_q;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic                      parity_bad_q;
    logic                      parity_err_q;
`endif

    // Stop-bit decisions are taken mid-bit and IDLE is re-entered right away, so a start
    // bit that immediately follows the stop bit is still caught on its first low cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_HALF_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_BIT_LAST) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == LAST_BIT_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == CNT_BIT_LAST) begin
                        cnt_q        <= '0;
                        parity_bad_q <= ^{shift_q, rx_s};
                        state_q      <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == CNT_BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (parity_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
`else
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign uart_received_data = data_q;
    assign uart_rx_valid      = valid_q;
    assign uart_frame_err     = frame_err_q;
    assign uart_rx_busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign uart_parity_err    = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed self-checking bench for uart_rx_deserializer at default timing (12 clocks per bit).
// Frames carry an even-parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx_deserializer;

    localparam int BIT = 12;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_CYCLES = 11 * BIT;
    localparam int LATENCY      = 2 + 6 + 10 * BIT + 1;
`else
    localparam int FRAME_CYCLES = 10 * BIT;
    localparam int LATENCY      = 2 + 6 + 9 * BIT + 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uartRxDIn = 1'b1;
    logic [7:0] uartReceivedData;
    logic       uartRxValid;
    logic       uartFrameErr;
    logic       uartRxBusy;
`ifdef UART_RX_PARITY_EN
    logic       uartParityErr;
`endif

    uart_rx_deserializer dut (
        .clk                (clk),
        .reset              (reset),
        .uart_rx_d_in       (uartRxDIn),
        .uart_received_data (uartReceivedData),
        .uart_rx_valid      (uartRxValid),
        .uart_frame_err     (uartFrameErr),
        .uart_rx_busy       (uartRxBusy)
`ifdef UART_RX_PARITY_EN
        ,
        .uart_parity_err    (uartParityErr)
`endif
    );

    always #5 clk = ~clk;

    int         cycleCnt = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         lastStart = 0;
    logic [7:0] rxData[$];
    int         rxCycle[$];
    int         frameErrCount = 0;
    int         busyCount = 0;
    int         bothHigh = 0;
`ifdef UART_RX_PARITY_EN
    int         parityErrCount = 0;
`endif

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Outputs are observed on the falling edge, half a cycle clear of the registers updating.
    always @(negedge clk) begin
        if (uartRxValid) begin
            rxData.push_back(uartReceivedData);
            rxCycle.push_back(cycleCnt);
        end
        if (uartFrameErr) frameErrCount++;
        if (uartRxBusy) busyCount++;
        if (uartRxValid && uartFrameErr) bothHigh++;
`ifdef UART_RX_PARITY_EN
        if (uartParityErr) parityErrCount++;
`endif
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearMonitor();
        rxData.delete();
        rxCycle.delete();
        frameErrCount = 0;
        busyCount = 0;
`ifdef UART_RX_PARITY_EN
        parityErrCount = 0;
`endif
    endtask

    task automatic driveBit(input logic b);
        uartRxDIn = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic idleBits(input int n);
        uartRxDIn = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        lastStart = cycleCnt;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
        driveBit(^data);
`endif
        driveBit(stopBit);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic applyParityFrame(input logic [7:0] data, input logic parityBit);
        lastStart = cycleCnt;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(parityBit);
        driveBit(1'b1);
    endtask
`endif

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        checkOutput("reset_data", 32'(uartReceivedData), 32'h00);
        checkOutput("reset_valid", 32'(uartRxValid), 32'h0);
        checkOutput("reset_ferr", 32'(uartFrameErr), 32'h0);
        checkOutput("reset_busy", 32'(uartRxBusy), 32'h0);
        reset = 1'b0;
        idleBits(2);

        clearMonitor();
        applyStimulus(8'hA5, 1'b1);
        idleBits(2);
        checkOutput("a5_count", 32'(rxData.size()), 32'd1);
        if (rxData.size() > 0) begin
            checkOutput("a5_data", 32'(rxData[0]), 32'hA5);
            checkOutput("a5_latency_in_window",
                        32'((rxCycle[0] - lastStart >= LATENCY - 1) && (rxCycle[0] - lastStart <= LATENCY + 1)),
                        32'd1);
        end
        checkOutput("a5_ferr", 32'(frameErrCount), 32'd0);
        checkOutput("a5_held", 32'(uartReceivedData), 32'hA5);

        clearMonitor();
        uartRxDIn = 1'b0;
        repeat (3) @(negedge clk);
        uartRxDIn = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("glitch_busy_cycles", 32'(busyCount), 32'd6);
        checkOutput("glitch_count", 32'(rxData.size()), 32'd0);
        checkOutput("glitch_ferr", 32'(frameErrCount), 32'd0);
        checkOutput("glitch_busy_after", 32'(uartRxBusy), 32'h0);

        clearMonitor();
        applyStimulus(8'h3C, 1'b0);
        uartRxDIn = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        checkOutput("break_busy", 32'(uartRxBusy), 32'h1);
        idleBits(2);
        checkOutput("break_ferr_once", 32'(frameErrCount), 32'd1);
        checkOutput("break_count", 32'(rxData.size()), 32'd0);
        checkOutput("break_data_kept", 32'(uartReceivedData), 32'hA5);
        clearMonitor();
        applyStimulus(8'h01, 1'b1);
        idleBits(2);
        checkOutput("after_break_count", 32'(rxData.size()), 32'd1);
        checkOutput("after_break_data", 32'(uartReceivedData), 32'h01);

        clearMonitor();
        for (int b = 0; b < 16; b++) applyStimulus(8'(b), 1'b1);
        idleBits(2);
        checkOutput("b2b_count", 32'(rxData.size()), 32'd16);
        for (int i = 0; i < 16 && i < rxData.size(); i++) begin
            checkOutput($sformatf("b2b_data_%0d", i), 32'(rxData[i]), 32'(i));
            if (i > 0) checkOutput($sformatf("b2b_gap_%0d", i), 32'(rxCycle[i] - rxCycle[i-1]), 32'(FRAME_CYCLES));
        end
        checkOutput("b2b_ferr", 32'(frameErrCount), 32'd0);

        clearMonitor();
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b1);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_data", 32'(uartReceivedData), 32'h00);
        checkOutput("midreset_busy", 32'(uartRxBusy), 32'h0);
        idleBits(6);
        checkOutput("midreset_no_pulse", 32'(rxData.size()), 32'd0);
        applyStimulus(8'h5A, 1'b1);
        idleBits(2);
        checkOutput("after_reset_count", 32'(rxData.size()), 32'd1);
        checkOutput("after_reset_data", 32'(uartReceivedData), 32'h5A);
        checkOutput("after_reset_ferr", 32'(frameErrCount), 32'd0);

`ifdef UART_RX_PARITY_EN
        clearMonitor();
        applyParityFrame(8'h07, 1'b0);
        idleBits(2);
        checkOutput("parity_bad_perr", 32'(parityErrCount), 32'd1);
        checkOutput("parity_bad_count", 32'(rxData.size()), 32'd0);
        checkOutput("parity_bad_data_kept", 32'(uartReceivedData), 32'h5A);
        clearMonitor();
        applyParityFrame(8'h07, 1'b1);
        idleBits(2);
        checkOutput("parity_ok_perr", 32'(parityErrCount), 32'd0);
        checkOutput("parity_ok_count", 32'(rxData.size()), 32'd1);
        checkOutput("parity_ok_data", 32'(uartReceivedData), 32'h07);
`endif

        checkOutput("valid_ferr_exclusive", 32'(bothHigh), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
